// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Parametrised up/down binary counter with a registered Gray
//                copy and a combinational look-ahead Gray value. Intended as
//                a CDC FIFO pointer generator and as a glitch-free multi-bit
//                count source.
//  Ports       : clk_i        - clock, rising edge
//                arst_i       - asynchronous active-high reset
//                clear_i      - synchronous clear to RESET_VAL
//                load_i       - synchronous load of load_val_i
//                load_val_i   - binary load value
//                en_i         - count enable, one step per cycle
//                dir_i        - 1 = up, 0 = down (only used when en_i=1)
//                bin_o        - registered binary count
//                gray_o       - registered Gray count
//                gray_next_o  - Gray of the value bin_o takes at the next edge
//                wrap_o       - registered pulse: the previous step wrapped
//                term_o       - bin_o is at the terminal value for dir_i
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned WRAP_EN   = 1
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] gray_next_o,
    output logic             wrap_o,
    output logic             term_o
);

    localparam logic [WIDTH-1:0] c_RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_RST_GRAY = c_RST_BIN ^ (c_RST_BIN >> 1);
    localparam logic [WIDTH-1:0] c_MAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
    localparam bit               c_WRAP     = (WRAP_EN != 0);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (r_bin == c_MAX);
    assign w_at_zero = (r_bin == c_ZERO);

    // Next-state selection: clear > load > count > hold. At a terminal value
    // the step either wraps (and flags it) or saturates by holding.
    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (clear_i) begin
            w_bin_next = c_RST_BIN;
        end else if (load_i) begin
            w_bin_next = load_val_i;
        end else if (en_i) begin
            if (dir_i) begin
                if (!w_at_max) begin
                    w_bin_next = r_bin + c_ONE;
                end else if (c_WRAP) begin
                    w_bin_next  = c_ZERO;
                    w_wrap_next = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_bin_next = r_bin - c_ONE;
                end else if (c_WRAP) begin
                    w_bin_next  = c_MAX;
                    w_wrap_next = 1'b1;
                end
            end
        end
    end

    // Gray flop is fed from the encoded next value rather than decoded from
    // r_bin, so the published Gray word comes straight off a register.
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_bin  <= c_RST_BIN;
            r_gray <= c_RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bin_o       = r_bin;
    assign gray_o      = r_gray;
    assign gray_next_o = w_gray_next;
    assign wrap_o      = r_wrap;
    assign term_o      = dir_i ? w_at_max : w_at_zero;

endmodule
`default_nettype wire
